clock_display_driver: RTL



---
 rtl/clock_display_pkg.sv | 60 ++++++
 rtl/clock_display_driver_bin_to_bcd_serial.sv | 30 +++
 rtl/clock_display_driver.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/clock_display_pkg.sv
// Shared types and constants for the clock display driver: conversion FSM
// states, edit-mode and digit-index encodings, and 7-segment codes.
package clock_display_pkg;

  localparam int unsigned FIELD_BITS = 6;
  localparam int unsigned NUM_DIGITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_SET_SEC,
    MODE_SET_MIN,
    MODE_SET_HR
  } mode_e;

  typedef enum logic [2:0] {
    DIG_SEC_ONES,
    DIG_SEC_TENS,
    DIG_MIN_ONES,
    DIG_MIN_TENS,
    DIG_HR_ONES,
    DIG_HR_TENS
  } digit_idx_e;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/clock_display_driver_bin_to_bcd_serial.sv
// Serial double-dabble converter for one 6-bit field: load, then six
// add-3/shift steps. bcd_next_c is the BCD value after the current shift.
module bin_to_bcd_serial (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  logic [5:0] bin_in,
  output logic [7:0] bcd_next_c
);

  logic [13:0] sr_q, sr_d, adj;

  always_comb begin
    adj = sr_q;
    if (adj[9:6] >= 4'd5)   adj[9:6]   = adj[9:6] + 4'd3;
    if (adj[13:10] >= 4'd5) adj[13:10] = adj[13:10] + 4'd3;
    sr_d = sr_q;
    if (load)       sr_d = {8'd0, bin_in};
    else if (shift) sr_d = {adj[12:0], 1'b0};
  end

  assign bcd_next_c = adj[12:5];

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

endmodule

// File: rtl/clock_display_driver.sv
// Converts binary h/m/s to BCD and scans six 7-segment digits.
// Optional edit-field blinking is built when DISPLAY_BLINK_EN is defined.
module clock_display_driver
  import clock_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 1000,
  parameter int unsigned BLINK_DIV = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] mode,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] digit_en,
  output logic       busy
);

  localparam int unsigned PRE_W = $clog2(SCAN_DIV);

  conv_state_e      state_q, state_d;
  logic [16:0]      snap_q, snap_d, cur_time;
  logic [2:0]       bit_q, bit_d;
  logic [1:0]       field_q, field_d;
  logic [2:0][7:0]  stage_q, stage_d;
  logic [5:0][3:0]  digits_q, digits_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d, busy_q, busy_d, tick;
  logic [5:0]       en_q, en_d;
  logic             conv_load, conv_shift;
  logic [5:0]       conv_bin;
  logic [7:0]       bcd_c;

  assign cur_time = {hours, minutes, seconds};

  bin_to_bcd_serial u_bcd (
    .clk        (clk),
    .reset      (reset),
    .load       (conv_load),
    .shift      (conv_shift),
    .bin_in     (conv_bin),
    .bcd_next_c (bcd_c)
  );

  // Sequencer: seconds, minutes, hours back to back; next field loads on last shift
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    bit_d      = bit_q;
    field_d    = field_q;
    stage_d    = stage_q;
    digits_d   = digits_q;
    conv_load  = 1'b0;
    conv_shift = 1'b0;
    conv_bin   = seconds;
    case (state_q)
      ST_IDLE: if (cur_time != snap_q) state_d = ST_LOAD;
      ST_LOAD: begin
        snap_d    = cur_time;
        conv_load = 1'b1;
        bit_d     = '0;
        field_d   = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        conv_shift = 1'b1;
        bit_d      = bit_q + 3'd1;
        if (bit_q == 3'(FIELD_BITS - 1)) begin
          bit_d = '0;
          case (field_q)
            2'd0: begin
              stage_d[0] = bcd_c;
              conv_load  = 1'b1;
              conv_bin   = snap_q[11:6];
              field_d    = 2'd1;
            end
            2'd1: begin
              stage_d[1] = bcd_c;
              conv_load  = 1'b1;
              conv_bin   = {1'b0, snap_q[16:12]};
              field_d    = 2'd2;
            end
            default: begin
              stage_d[2] = bcd_c;
              state_d    = ST_COMMIT;
            end
          endcase
        end
      end
      ST_COMMIT: begin
        digits_d = stage_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign tick = (pre_q == PRE_W'(SCAN_DIV - 1));

`ifdef DISPLAY_BLINK_EN
  localparam int unsigned FR_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [FR_W-1:0] frame_q, frame_d;
  logic            phase_q, phase_d, blank_c;

  // Phase flips every BLINK_DIV full scan frames
  always_comb begin
    frame_d = frame_q;
    phase_d = phase_q;
    if (tick && idx_q == 3'(DIG_HR_TENS)) begin
      if (frame_q == FR_W'(BLINK_DIV - 1)) begin
        frame_d = '0;
        phase_d = ~phase_q;
      end else begin
        frame_d = frame_q + FR_W'(1);
      end
    end
    blank_c = phase_q && (mode != MODE_RUN) && (idx_q[2:1] == (mode - 2'd1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      frame_q <= frame_d;
      phase_q <= phase_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^{mode, 32'(BLINK_DIV)};
`endif

  // Scan: outputs follow the digit index one cycle after it advances
  always_comb begin
    pre_d = tick ? '0 : pre_q + PRE_W'(1);
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == 3'(DIG_HR_TENS)) ? 3'd0 : idx_q + 3'd1;
    seg_d = digit_to_seg(digits_q[idx_q]);
    en_d  = 6'd1 << idx_q;
    dp_d  = (idx_q == 3'(DIG_MIN_ONES)) || (idx_q == 3'(DIG_HR_ONES));
`ifdef DISPLAY_BLINK_EN
    if (blank_c) seg_d = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_LOAD;
      snap_q   <= '0;
      bit_q    <= '0;
      field_q  <= '0;
      stage_q  <= '0;
      digits_q <= '0;
      pre_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_0;
      dp_q     <= 1'b0;
      en_q     <= 6'b000001;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      bit_q    <= bit_d;
      field_q  <= field_d;
      stage_q  <= stage_d;
      digits_q <= digits_d;
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
    end
  end

  assign seg      = seg_q;
  assign dp       = dp_q;
  assign digit_en = en_q;
  assign busy     = busy_q;

endmodule
